// File: rtl/axi_lite_mem_slave.sv
// Single-beat AXI4-Lite-style memory responder.
// The module contains a word-organised RAM with per-byte write strobes.
// The read and write engines are independent FSMs that run concurrently.
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where VALID and READY are both 1. The source holds VALID and its payload
// stable until that edge, and READY/VALID outputs here are always registered.
`timescale 1ns/1ps
module axi_lite_mem_slave #(
   parameter int ADDR_W       = 32,
   parameter int DEPTH_WORDS  = 256,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [31:0]       RDATA,
   output logic              RVALID,
   input  logic              RREADY,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [31:0]       WDATA,
   input  logic [3:0]        WSTRB,
   input  logic              WVALID,
   output logic              WREADY,
   output logic              BVALID,
   input  logic              BREADY
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_COMMIT, W_RESP} w_state_t;

   r_state_t r_state;
   w_state_t w_state;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [IDX_W-1:0] ar_idx;
   logic [IDX_W-1:0] aw_idx;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_data;
   logic [3:0]       w_strb;
   logic             unused_addr_bits;

   // Byte offset and bits above the RAM size are ignored, so addresses wrap.
   assign ar_idx = ARADDR[IDX_W+1:2];
   assign aw_idx = AWADDR[IDX_W+1:2];
   assign unused_addr_bits = ^{ARADDR, AWADDR};

   // Read engine: accept one address, count out the latency, then hold R until taken.
   // R_LAT is always visited; with a counter load of READ_LATENCY-1 the data
   // edge lands exactly READ_LATENCY edges after the AR handshake edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= R_IDLE;
         ARREADY <= 1'b1;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ARVALID && ARREADY) begin
                  r_idx   <= ar_idx;
                  ARREADY <= 1'b0;
                  r_cnt   <= LAT_LOAD;
                  r_state <= R_LAT;
               end
            end
            R_LAT: begin
               if (r_cnt == '0) begin
                  // Samples the pre-write value if a commit hits this word on the same edge.
                  RDATA   <= mem[r_idx];
                  RVALID  <= 1'b1;
                  r_state <= R_RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            R_RESP: begin
               if (RREADY) begin
                  RVALID  <= 1'b0;
                  ARREADY <= 1'b1;
                  r_state <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Write engine: collect AW and W in any order, commit one cycle later, then hold B until taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state <= W_IDLE;
         AWREADY <= 1'b1;
         WREADY  <= 1'b1;
         BVALID  <= 1'b0;
         w_idx   <= '0;
         w_data  <= '0;
         w_strb  <= '0;
      end else begin
         case (w_state)
            W_IDLE, W_COLLECT: begin
               // Both readies low means both halves are already captured.
               if (!AWREADY && !WREADY) begin
                  w_state <= W_COMMIT;
               end else begin
                  if (AWVALID && AWREADY) begin
                     w_idx   <= aw_idx;
                     AWREADY <= 1'b0;
                     w_state <= W_COLLECT;
                  end
                  if (WVALID && WREADY) begin
                     w_data  <= WDATA;
                     w_strb  <= WSTRB;
                     WREADY  <= 1'b0;
                     w_state <= W_COLLECT;
                  end
               end
            end
            W_COMMIT: begin
               BVALID  <= 1'b1;
               w_state <= W_RESP;
            end
            W_RESP: begin
               if (BREADY) begin
                  BVALID  <= 1'b0;
                  AWREADY <= 1'b1;
                  WREADY  <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // RAM write port: byte-wise update on the commit edge; contents are never reset.
   always_ff @(posedge clk) begin
      if (w_state == W_COMMIT) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

endmodule
